bf_pass_scheduler: RTL and testbench

Sequences the Bellman-Ford relaxation engine across its passes over the graph. Launches one full relaxation pass at a time and collects the engine's update pulses. Stops early when a pass makes no update; otherwise runs N passes, where the last one is a negative-cycle check. It then streams the final working-memory node records into output memory. It sits between the top-level start/done control and the relaxation engine, and owns the output-memory write port.

---
 rtl/bf_pkg.sv | 27 ++
 rtl/bf_pass_scheduler_if.sv | 33 +++
 rtl/bf_copy_pipe.sv | 60 ++++++
 rtl/bf_pass_scheduler.sv | 120 ++++++++++++
 tb/tb_bf_pass_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the Bellman-Ford pass scheduler.
// Field positions describe the node record held in each working-memory word.
package bf_pkg;

    localparam int BF_ADDR_W = 13;
    localparam int BF_DATA_W = 128;

    localparam int INF_BIT = 127;
    localparam int DIST_HI = 126;
    localparam int DIST_LO = 119;
    localparam int PRED_HI = 118;
    localparam int PRED_LO = 111;
    localparam int FLAG_HI = 110;
    localparam int FLAG_LO = 107;
    localparam int NEG_BIT = 106;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_COPY   = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/bf_pass_scheduler_if.sv
// Control, engine handshake and memory ports of the pass scheduler.
// The scheduler uses the slave view; whoever drives it uses master.
interface bf_pass_scheduler_if import bf_pkg::*; #(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W
);
    logic              start;
    logic [7:0]        num_nodes;
    logic              busy;
    logic              done;
    logic              neg_cycle;
    logic [7:0]        pass_count;
    logic              eng_start;
    logic              eng_done;
    logic              eng_update;
    logic [ADDR_W-1:0] WMAR;
    logic [DATA_W-1:0] WMDR;
    logic [ADDR_W-1:0] OMWAR;
    logic [DATA_W-1:0] OMWDR;
    logic              OMWE;

    modport slave (
        input  start, num_nodes, eng_done, eng_update, WMDR,
        output busy, done, neg_cycle, pass_count, eng_start,
               WMAR, OMWAR, OMWDR, OMWE
    );

    modport master (
        output start, num_nodes, eng_done, eng_update, WMDR,
        input  busy, done, neg_cycle, pass_count, eng_start,
               WMAR, OMWAR, OMWDR, OMWE
    );
endinterface

// File: rtl/bf_copy_pipe.sv
// Issues WM addresses 1..N one per cycle and delays each by RD_LAT cycles
// so the OM write lines up with the returning read data.
module bf_copy_pipe #(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_go,
    input  logic [7:0]        i_n,
    output logic              o_issue_last,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_wmar,
    output logic [ADDR_W-1:0] o_omwar,
    output logic              o_omwe
);
    logic                           r_active;
    logic [7:0]                     r_k;
    logic [RD_LAT:1]                r_vld;
    logic [RD_LAT:1][ADDR_W-1:0]    r_adr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_k      <= '0;
            r_vld    <= '0;
            r_adr    <= '0;
        end else begin
            if (i_go) begin
                r_active <= 1'b1;
                r_k      <= 8'd1;
            end else if (r_active) begin
                if (r_k == i_n) r_active <= 1'b0;
                else            r_k      <= r_k + 8'd1;
            end
            // Address stages load only behind a valid beat, so the last
            // stage holds the most recent OM address between writes.
            r_vld[1] <= r_active;
            if (r_active) r_adr[1] <= ADDR_W'(r_k - 8'd1);
            for (int i = 2; i <= RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) r_adr[i] <= r_adr[i-1];
            end
        end
    end

    // Empty means nothing is queued behind the beat now in the final stage.
    always_comb begin
        o_empty = !r_active;
        for (int i = 1; i < RD_LAT; i++) begin
            if (r_vld[i]) o_empty = 1'b0;
        end
    end

    assign o_issue_last = r_active && (r_k == i_n);
    assign o_wmar       = r_active ? ADDR_W'(r_k) : '0;
    assign o_omwar      = r_adr[RD_LAT];
    assign o_omwe       = r_vld[RD_LAT];

endmodule

// File: rtl/bf_pass_scheduler.sv
// Runs relaxation passes until one makes no update or N passes complete,
// then copies node records 1..N from working memory to output memory.
module bf_pass_scheduler import bf_pkg::*; #(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    bf_pass_scheduler_if.slave  bus
);
    localparam logic [DATA_W-1:0] REC_MASK =
        {{(DATA_W-FLAG_LO){1'b1}}, {FLAG_LO{1'b0}}};

    state_e            r_state, w_next;
    logic [7:0]        r_n;
    logic [7:0]        r_pass;
    logic [7:0]        w_pass_inc;
    logic              r_changed;
    logic              r_neg;
    logic              w_go;
    logic              w_issue_last;
    logic              w_empty;
    logic              w_omwe;
    logic [DATA_W-1:0] w_rec;
    logic [DATA_W-1:0] r_omwdr;

    always_comb begin
        w_next     = r_state;
        w_go       = 1'b0;
        w_pass_inc = (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) w_next = (bus.num_nodes == 8'd0) ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done) w_next = S_EVAL;
            end
            S_EVAL: begin
                if (!r_changed || w_pass_inc == r_n) begin
                    w_next = S_COPY;
                    w_go   = 1'b1;
                end else begin
                    w_next = S_LAUNCH;
                end
            end
            S_COPY: begin
                if (w_issue_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_empty) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_pass    <= '0;
            r_changed <= 1'b0;
            r_neg     <= 1'b0;
            r_omwdr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_n       <= bus.num_nodes;
                        r_pass    <= '0;
                        r_changed <= 1'b0;
                        r_neg     <= 1'b0;
                    end
                end
                // An update coinciding with eng_done still belongs to this pass.
                S_WAIT: begin
                    if (bus.eng_update) r_changed <= 1'b1;
                end
                S_EVAL: begin
                    r_pass <= w_pass_inc;
                    if (r_changed && w_pass_inc == r_n) r_neg     <= 1'b1;
                    if (w_next == S_LAUNCH)             r_changed <= 1'b0;
                end
                default: ;
            endcase
            if (w_omwe) r_omwdr <= w_rec;
        end
    end

    bf_copy_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_copy (
        .clock        (clock),
        .reset        (reset),
        .i_go         (w_go),
        .i_n          (r_n),
        .o_issue_last (w_issue_last),
        .o_empty      (w_empty),
        .o_wmar       (bus.WMAR),
        .o_omwar      (bus.OMWAR),
        .o_omwe       (w_omwe)
    );

    // Keep the record fields, stamp the run's negative-cycle verdict, zero the rest.
    assign w_rec = (bus.WMDR & REC_MASK) | (DATA_W'(r_neg) << NEG_BIT);

    assign bus.OMWE       = w_omwe;
    assign bus.OMWDR      = w_omwe ? w_rec : r_omwdr;
    assign bus.eng_start  = (r_state == S_LAUNCH);
    assign bus.done       = (r_state == S_DONE);
    assign bus.busy       = (r_state == S_LAUNCH) || (r_state == S_WAIT) ||
                            (r_state == S_EVAL)   || (r_state == S_COPY) ||
                            (r_state == S_DRAIN);
    assign bus.neg_cycle  = r_neg;
    assign bus.pass_count = r_pass;

endmodule

// File: tb/tb_bf_pass_scheduler.sv
// Randomized bench: an engine model replays per-pass update plans, a
// scoreboard queue holds expected OM writes, run-level results are checked at done.
module tb_bf_pass_scheduler;
    import bf_pkg::*;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int RL = 2;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            starts_seen = 0;
    int            last_issue = -1;
    wr_t           exp_q[$];
    int            upd_plan[$];
    bit            sim_plan[$];
    logic [DW-1:0] wm [0:255];
    logic [AW-1:0] d1 = '0;
    logic [AW-1:0] d2 = '0;

    bf_pass_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bf_pass_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Working memory with RD_LAT cycles of read latency.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        d1  <= bus.WMAR;
        d2  <= d1;
    end
    assign bus.WMDR = wm[d2[7:0]];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for OM writes.
    always @(negedge clock) begin
        if (reset && bus.WMAR != '0) last_issue = cyc;
        if (bus.OMWE === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL om_spurious: got write to %0h expected none", bus.OMWAR);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("om_addr", DW'(bus.OMWAR), DW'(e.a));
                check("om_data", bus.OMWDR, e.d);
            end
        end
    end

    // Engine model: per pass, emits the planned number of update pulses then eng_done.
    initial begin
        int nu;
        bit sm;
        bus.eng_done   = 1'b0;
        bus.eng_update = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.eng_start === 1'b1) begin
                nu = (starts_seen < upd_plan.size()) ? upd_plan[starts_seen] : 0;
                sm = (starts_seen < sim_plan.size()) ? sim_plan[starts_seen] : 1'b0;
                starts_seen++;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                for (int u = 0; u < nu; u++) begin
                    if (sm && u == nu - 1) break;
                    bus.eng_update = 1'b1;
                    @(negedge clock);
                    bus.eng_update = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                end
                bus.eng_done   = 1'b1;
                bus.eng_update = sm && (nu > 0);
                @(negedge clock);
                bus.eng_done   = 1'b0;
                bus.eng_update = 1'b0;
            end
        end
    end

    task automatic run_case(input int n, input bit extra);
        int  k;
        bit  neg;
        int  w;
        int  bound;
        // Passes stop at the first one with no update; all N changing means a negative cycle.
        k   = 0;
        neg = (n > 0);
        for (int p = 0; p < n; p++) begin
            k = p + 1;
            if (upd_plan[p] == 0) begin
                neg = 1'b0;
                break;
            end
        end
        for (int i = 1; i <= n; i++)
            exp_q.push_back('{a: AW'(i - 1), d: {wm[i][127:107], neg, 106'b0}});
        starts_seen = 0;
        last_issue  = -1;
        @(negedge clock);
        bus.num_nodes = 8'(n);
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        w     = 1;
        bound = 300 * (n + 1) + 50;
        while (bus.done !== 1'b1 && w < bound) begin
            if (n > 0 && w == 2) check("busy_mid", DW'(bus.busy), DW'(1));
            bus.start = extra && (w == 2);
            if (extra && w == 2) bus.num_nodes = 8'($urandom_range(0, 255));
            @(negedge clock);
            w++;
        end
        bus.start = 1'b0;
        check("done_reached", DW'(bus.done), DW'(1));
        check("pass_count", DW'(bus.pass_count), DW'(k));
        check("neg_cycle", DW'(bus.neg_cycle), DW'(neg));
        check("eng_starts", DW'(starts_seen), DW'(k));
        check("busy_in_done", DW'(bus.busy), DW'(0));
        check("om_writes_left", DW'(exp_q.size()), DW'(0));
        if (n == 0) check("n0_latency", DW'(w), DW'(1));
        else        check("done_latency", DW'(cyc - last_issue), DW'(RL + 1));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   DW'(bus.busy), '0);
        check({tag, "_done"},   DW'(bus.done), '0);
        check({tag, "_estart"}, DW'(bus.eng_start), '0);
        check({tag, "_pass"},   DW'(bus.pass_count), '0);
        check({tag, "_neg"},    DW'(bus.neg_cycle), '0);
        check({tag, "_omwe"},   DW'(bus.OMWE), '0);
        check({tag, "_wmar"},   DW'(bus.WMAR), '0);
        check({tag, "_omwar"},  DW'(bus.OMWAR), '0);
        check({tag, "_omwdr"},  bus.OMWDR, '0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_nodes = '0;
        for (int i = 0; i < 256; i++) wm[i] = {$urandom, $urandom, $urandom, $urandom};
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        upd_plan = {2, 0, 0, 0};    sim_plan = {0, 0, 0, 0};    run_case(4, 0);
        upd_plan = {1, 2, 1};       sim_plan = {0, 0, 0};       run_case(3, 0);
        upd_plan = {1, 0};          sim_plan = {1, 0};          run_case(2, 0);
        upd_plan = {};              sim_plan = {};              run_case(0, 0);
        upd_plan = {1, 1, 0};       sim_plan = {0, 0, 0};       run_case(3, 1);
        upd_plan = {3, 3, 3};       sim_plan = {1, 0, 1};       run_case(3, 0);
        upd_plan = {1, 1, 1, 1, 0}; sim_plan = {0, 1, 0, 0, 0}; run_case(5, 0);

        // Abort a run while the engine pass is in flight.
        upd_plan = {1, 1, 1, 1}; sim_plan = {0, 0, 0, 0};
        starts_seen = 0;
        @(negedge clock);
        bus.num_nodes = 8'd4;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        check("busy_before_abort", DW'(bus.busy), DW'(1));
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("idle_after_abort_busy", DW'(bus.busy), '0);
        check("idle_after_abort_done", DW'(bus.done), '0);

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 8);
            upd_plan.delete();
            sim_plan.delete();
            for (int p = 0; p < n; p++) begin
                upd_plan.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)));
                sim_plan.push_back(1'($urandom_range(0, 1)));
            end
            run_case(n, 1'($urandom_range(0, 1)));
        end

        upd_plan.delete();
        sim_plan.delete();
        for (int p = 0; p < 255; p++) begin
            upd_plan.push_back(1);
            sim_plan.push_back(1'b0);
        end
        run_case(255, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
